// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared types and default constants for the memory responder
// Revision: 1.0
// ============================================================================
package mem_pkg;
  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_LATENCY     = 2;
  localparam int DATA_W              = 32;
  localparam int ADDR_W              = 32;
  localparam int CNT_W               = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// mem_responder_if : request/response bus between an initiator and responder
// Revision: 1.0
// ============================================================================
interface mem_responder_if;
  import mem_pkg::*;

  logic              ReqValid;
  logic              ReqWrite;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WrData;
  logic              ReqReady;
  logic              RespValid;
  logic [DATA_W-1:0] RdData;
  logic              AddrErr;

  modport master (
    output ReqValid, ReqWrite, Addr, WrData,
    input  ReqReady, RespValid, RdData, AddrErr
  );

  modport slave (
    input  ReqValid, ReqWrite, Addr, WrData,
    output ReqReady, RespValid, RdData, AddrErr
  );
endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// mem_array : single-port synchronous RAM with write enable and registered read
// Revision: 1.0
// ============================================================================
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  wire logic              Clk,
  input  wire logic              i_en,
  input  wire logic              i_we,
  input  wire logic [IDX_W-1:0]  i_idx,
  input  wire logic [DATA_W-1:0] i_wdata,
  output logic      [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rdata;

  // Storage is intentionally not reset; contents survive Reset.
  always_ff @(posedge Clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_idx] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// mem_responder : fixed-latency word memory responder with address checking
// Revision: 1.0
// ============================================================================
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input wire logic       Clk,
  input wire logic       Reset,
  mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_write;
  logic                r_err;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ready;
  logic                r_resp_valid;
  logic                r_addr_err;
  logic                r_rd_sel;

  logic                w_addr_err;
  logic                w_ram_en;
  logic [DATA_W-1:0]   w_ram_rdata;

  // Misaligned, or any address bit beyond the word index is set.
  assign w_addr_err = (bus.Addr[1:0] != 2'b00) || (|bus.Addr[ADDR_W-1:IDX_W+2]);

  // Storage is touched only on the WAIT -> RESP edge; a concurrent Reset aborts it.
  assign w_ram_en = (r_state == ST_WAIT) && (r_cnt == '0) && !r_err && !Reset;

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem_array (
    .Clk     (Clk),
    .i_en    (w_ram_en),
    .i_we    (r_write),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_err        <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_addr_err   <= 1'b0;
      r_rd_sel     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.ReqValid) begin
            r_write <= bus.ReqWrite;
            r_err   <= w_addr_err;
            r_idx   <= bus.Addr[IDX_W+1:2];
            r_wdata <= bus.WrData;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_ready <= 1'b0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_resp_valid <= 1'b1;
            r_addr_err   <= r_err;
            r_rd_sel     <= !r_err && !r_write;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_addr_err   <= 1'b0;
          r_rd_sel     <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ReqReady  = r_ready;
  assign bus.RespValid = r_resp_valid;
  assign bus.AddrErr   = r_addr_err;
  assign bus.RdData    = r_rd_sel ? w_ram_rdata : '0;
endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_mem_responder : scoreboard bench for mem_responder (LATENCY 2, 1 and 15)
// Revision: 1.0
// ============================================================================
module tb_mem_responder;
  localparam int LAT = 2;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  exp_t sb[$];
  logic [31:0] model [256];

  mem_responder_if bus ();
  mem_responder_if bus1 ();
  mem_responder_if bus15 ();

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) u_dut (
    .Clk (clk), .Reset (rst), .bus (bus.slave));
  mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .Clk (clk), .Reset (rst), .bus (bus1.slave));
  mem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u_dut15 (
    .Clk (clk), .Reset (rst), .bus (bus15.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pop the next expectation on every response; outputs must be quiet otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.RespValid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_data", bus.RdData, e.rd);
          chk("addr_err", {31'd0, bus.AddrErr}, {31'd0, e.err});
        end
      end else begin
        chk("idle_outputs", bus.RdData | {31'd0, bus.AddrErr}, 32'd0);
      end
    end
  end

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
  endfunction

  task automatic push_exp(input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.err = addr_bad(a);
    e.rd  = 32'd0;
    if (!e.err) begin
      if (wr) model[a[9:2]] = d;
      else    e.rd = model[a[9:2]];
    end
    sb.push_back(e);
  endtask

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    int lowc;
    int g;
    @(negedge clk);
    g = 0;
    while (!bus.ReqReady && g < 50) begin @(negedge clk); g++; end
    bus.ReqValid = 1'b1; bus.ReqWrite = wr; bus.Addr = a; bus.WrData = d;
    push_exp(wr, a, d);
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs after acceptance; the latched request must not change.
    bus.ReqValid = 1'b0; bus.ReqWrite = ~wr; bus.Addr = a ^ 32'h4; bus.WrData = ~d;
    n = 1;
    lowc = bus.ReqReady ? 0 : 1;
    while (!bus.RespValid && n < 50) begin
      @(negedge clk); n++;
      if (!bus.ReqReady) lowc++;
    end
    chk("latency", n, LAT + 1);
    chk("ready_low", lowc, LAT + 1);
    @(negedge clk);
    chk("ready_back", {31'd0, bus.ReqReady}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    int t_prev;
    bus.ReqValid = 0; bus.ReqWrite = 0; bus.Addr = 0; bus.WrData = 0;
    bus1.ReqValid = 0; bus1.ReqWrite = 0; bus1.Addr = 0; bus1.WrData = 0;
    bus15.ReqValid = 0; bus15.ReqWrite = 0; bus15.Addr = 0; bus15.WrData = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'd0, bus.ReqReady}, 32'd1);
    chk("rst_resp", {31'd0, bus.RespValid}, 32'd0);
    chk("rst_rdata", bus.RdData, 32'd0);
    chk("rst_err", {31'd0, bus.AddrErr}, 32'd0);
    mon_en = 1'b1;

    do_req(1, 32'h10, 32'hDEADBEEF);
    do_req(1, 32'h14, 32'h00000001);
    do_req(0, 32'h10, 32'h0);
    do_req(0, 32'h14, 32'h0);
    do_req(1, 32'h0, 32'hCAFEF00D);
    do_req(0, 32'h12, 32'h0);
    do_req(0, 32'h400, 32'h0);
    do_req(1, 32'h3, 32'h55555555);
    do_req(0, 32'h0, 32'h0);
    do_req(1, 32'h3FC, 32'hA5A5A5A5);
    do_req(0, 32'h3FC, 32'h0);
    do_req(1, 32'h20, 32'h22222222);

    // Abort a write with Reset during its second WAIT cycle.
    @(negedge clk);
    bus.ReqValid = 1; bus.ReqWrite = 1; bus.Addr = 32'h20; bus.WrData = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    bus.ReqValid = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {31'd0, bus.ReqReady}, 32'd1);
    chk("abort_resp", {31'd0, bus.RespValid}, 32'd0);
    repeat (4) @(negedge clk);
    do_req(0, 32'h20, 32'h0);

    // Reset wins over a simultaneous request.
    @(negedge clk);
    rst = 1'b1;
    bus.ReqValid = 1; bus.ReqWrite = 1; bus.Addr = 32'h20; bus.WrData = 32'h33333333;
    @(negedge clk);
    rst = 1'b0; bus.ReqValid = 0;
    chk("prec_ready0", {31'd0, bus.ReqReady}, 32'd1);
    @(negedge clk);
    chk("prec_ready1", {31'd0, bus.ReqReady}, 32'd1);
    do_req(0, 32'h20, 32'h0);

    // ReqValid held high: one acceptance per LAT+2 cycles, WAIT-time data ignored.
    @(negedge clk);
    bus.ReqValid = 1; bus.ReqWrite = 1; bus.Addr = 32'h30; bus.WrData = 32'hA0000000;
    push_exp(1, 32'h30, 32'hA0000000);
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      g = 0;
      while (!bus.ReqReady && g < 50) begin @(negedge clk); g++; end
      @(posedge clk);
      #1;
      if (k > 0) chk("b2b_spacing", cyc - t_prev, LAT + 2);
      t_prev = cyc;
      @(negedge clk);
      bus.WrData = 32'hBAD00000 | k;
      bus.Addr   = (k % 2 == 0) ? 32'h34 : 32'h30;
      g = 0;
      while (!bus.RespValid && g < 50) begin @(negedge clk); g++; end
      if (k < 3) begin
        bus.WrData = 32'hA0000000 | (k + 1);
        push_exp(1, bus.Addr, bus.WrData);
      end else begin
        bus.ReqValid = 0;
      end
    end
    do_req(0, 32'h30, 32'h0);
    do_req(0, 32'h34, 32'h0);

    // Latency of the LATENCY=1 and LATENCY=15 builds.
    @(negedge clk);
    bus1.ReqValid = 1; bus1.ReqWrite = 1; bus1.Addr = 32'h8; bus1.WrData = 32'h5;
    @(posedge clk);
    @(negedge clk);
    bus1.ReqValid = 0;
    g = 1;
    while (!bus1.RespValid && g < 40) begin @(negedge clk); g++; end
    chk("lat1", g, 2);
    chk("lat1_err", {31'd0, bus1.AddrErr}, 32'd0);

    @(negedge clk);
    bus15.ReqValid = 1; bus15.ReqWrite = 1; bus15.Addr = 32'h8; bus15.WrData = 32'h5;
    @(posedge clk);
    @(negedge clk);
    bus15.ReqValid = 0;
    g = 1;
    while (!bus15.RespValid && g < 40) begin @(negedge clk); g++; end
    chk("lat15", g, 16);
    chk("lat15_err", {31'd0, bus15.AddrErr}, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
